// File: rtl/elevador_scan_pkg.sv
// Shared types for the SCAN elevator: FSM state encoding, direction constants
// and the width helper for the shared travel/door counter.
package elevador_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_MOVE_UP   = 2'd1,
        ST_MOVE_DOWN = 2'd2,
        ST_DOOR_OPEN = 2'd3
    } estado_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One counter serves both travel and door timing, so it is sized for the longer of the two.
    function automatic int largura_cnt(input int t_viagem, input int t_porta);
        int m;
        m = (t_viagem > t_porta) ? t_viagem : t_porta;
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/elevador_scan_if.sv
// Call-button/sensor and motor/door bus of the SCAN elevator controller.
// The controller takes the slave side; whoever issues calls takes the master side.
interface elevador_scan_if #(
    parameter int N_ANDARES  = 5,
    parameter int CAPACIDADE = 8
);
    localparam int WA = $clog2(N_ANDARES);
    localparam int WP = $clog2(CAPACIDADE + 1);

    logic [N_ANDARES-1:0] req;
    logic                 person_enter;
    logic                 person_exit;
    logic                 motor_up;
    logic                 motor_down;
    logic                 door_open;
    logic                 busy;
    logic                 direcao;
    logic                 lotado;
    logic [WA-1:0]        andar_atual;
    logic [WA-1:0]        andar_alvo;
    logic [N_ANDARES-1:0] pendentes;
    logic [WP-1:0]        num_people;

    modport master (
        output req, person_enter, person_exit,
        input  motor_up, motor_down, door_open, busy, direcao, lotado,
               andar_atual, andar_alvo, pendentes, num_people
    );

    modport slave (
        input  req, person_enter, person_exit,
        output motor_up, motor_down, door_open, busy, direcao, lotado,
               andar_atual, andar_alvo, pendentes, num_people
    );

endinterface

// File: rtl/elevador_scan_alvo.sv
// Combinational search over the pending set: calls above/below the current floor
// and the next floor to serve (nearest in the current direction first).
module elevador_scan_alvo
    import elevador_scan_pkg::*;
#(
    parameter  int N_ANDARES = 5,
    localparam int WA        = $clog2(N_ANDARES)
) (
    input  logic [N_ANDARES-1:0] pendentes,
    input  logic [WA-1:0]        andar_atual,
    input  logic                 direcao,
    output logic                 acima,
    output logic                 abaixo,
    output logic [WA-1:0]        andar_alvo
);

    logic [WA-1:0] perto_acima;
    logic [WA-1:0] perto_abaixo;

    // Ascending scan: the first hit above is the nearest above, the last hit below the nearest below.
    always_comb begin
        acima        = 1'b0;
        abaixo       = 1'b0;
        perto_acima  = andar_atual;
        perto_abaixo = andar_atual;
        for (int i = 0; i < N_ANDARES; i++) begin
            if (pendentes[i] && (i > int'(andar_atual))) begin
                if (!acima) perto_acima = WA'(i);
                acima = 1'b1;
            end
            if (pendentes[i] && (i < int'(andar_atual))) begin
                perto_abaixo = WA'(i);
                abaixo       = 1'b1;
            end
        end
    end

    assign andar_alvo = (direcao == DIR_UP)
                      ? (acima  ? perto_acima  : (abaixo ? perto_abaixo : andar_atual))
                      : (abaixo ? perto_abaixo : (acima  ? perto_acima  : andar_atual));

endmodule

// File: rtl/elevador_scan.sv
// SCAN elevator controller: latches floor calls, sweeps in one direction while calls
// remain ahead, with timed travel, a retriggering door timer and occupancy limiting.
module elevador_scan
    import elevador_scan_pkg::*;
#(
    parameter int N_ANDARES  = 5,
    parameter int CAPACIDADE = 8,
    parameter int T_VIAGEM   = 4,
    parameter int T_PORTA    = 6
) (
    input logic            clk,
    input logic            reset_n,
    elevador_scan_if.slave bus
);

    localparam int WA = $clog2(N_ANDARES);
    localparam int WP = $clog2(CAPACIDADE + 1);
    localparam int WT = largura_cnt(T_VIAGEM, T_PORTA);

    localparam logic [WT-1:0]        VIAGEM_FIM = WT'(T_VIAGEM - 1);
    localparam logic [WT-1:0]        PORTA_FIM  = WT'(T_PORTA - 1);
    localparam logic [WP-1:0]        CAP        = WP'(CAPACIDADE);
    localparam logic [N_ANDARES-1:0] UM         = {{(N_ANDARES-1){1'b0}}, 1'b1};

    estado_t              st;
    estado_t              ch_st;
    logic                 ch_dir;
    logic                 dir;
    logic [WA-1:0]        andar;
    logic [WA-1:0]        andar_acima;
    logic [WA-1:0]        andar_abaixo;
    logic [WA-1:0]        alvo;
    logic [N_ANDARES-1:0] pend;
    logic [N_ANDARES-1:0] clr;
    logic [N_ANDARES-1:0] pend_eff;
    logic [WP-1:0]        npes;
    logic [WT-1:0]        cnt;
    logic [3:0]           out_q;
    logic                 acima;
    logic                 abaixo;
    logic                 lotado;
    logic                 ent_ok;
    logic                 sai_ok;
    logic                 ambos;
    logic                 aceito;

    // {busy, door_open, motor_down, motor_up}
    function automatic logic [3:0] saidas(input estado_t s);
        case (s)
            ST_MOVE_UP:   return 4'b1001;
            ST_MOVE_DOWN: return 4'b1010;
            ST_DOOR_OPEN: return 4'b1100;
            default:      return 4'b0000;
        endcase
    endfunction

    elevador_scan_alvo #(.N_ANDARES(N_ANDARES)) u_alvo (
        .pendentes  (pend),
        .andar_atual(andar),
        .direcao    (dir),
        .acima      (acima),
        .abaixo     (abaixo),
        .andar_alvo (alvo)
    );

    assign andar_acima  = andar + 1'b1;
    assign andar_abaixo = andar - 1'b1;
    assign clr          = (st == ST_DOOR_OPEN) ? (UM << andar) : '0;
    // The floor being served is masked so a short door never re-chooses itself.
    assign pend_eff     = pend & ~clr;

    assign lotado = (npes == CAP);
    assign ent_ok = bus.person_enter & ~bus.person_exit & ~lotado;
    assign sai_ok = bus.person_exit & ~bus.person_enter & (npes != '0);
    assign ambos  = bus.person_enter & bus.person_exit;
    assign aceito = (st == ST_DOOR_OPEN) & (ent_ok | sai_ok | ambos);

    always_comb begin
        ch_st  = ST_IDLE;
        ch_dir = dir;
        if (pend_eff[andar]) begin
            ch_st = ST_DOOR_OPEN;
        end else if ((dir == DIR_UP) && acima) begin
            ch_st = ST_MOVE_UP;
        end else if ((dir == DIR_DOWN) && abaixo) begin
            ch_st = ST_MOVE_DOWN;
        end else if (abaixo) begin
            ch_st  = ST_MOVE_DOWN;
            ch_dir = DIR_DOWN;
        end else if (acima) begin
            ch_st  = ST_MOVE_UP;
            ch_dir = DIR_UP;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st    <= ST_IDLE;
            dir   <= DIR_UP;
            andar <= '0;
            cnt   <= '0;
            out_q <= '0;
        end else begin
            case (st)
                ST_IDLE: begin
                    st    <= ch_st;
                    dir   <= ch_dir;
                    cnt   <= '0;
                    out_q <= saidas(ch_st);
                end
                ST_MOVE_UP: begin
                    if (cnt != VIAGEM_FIM) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
                        andar <= andar_acima;
                        // With the new floor not pending, "calls above old floor" equals "calls above new floor".
                        if (pend[andar_acima]) begin
                            st    <= ST_DOOR_OPEN;
                            out_q <= saidas(ST_DOOR_OPEN);
                        end else if (!acima) begin
                            st    <= ST_IDLE;
                            out_q <= saidas(ST_IDLE);
                        end
                    end
                end
                ST_MOVE_DOWN: begin
                    if (cnt != VIAGEM_FIM) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt   <= '0;
                        andar <= andar_abaixo;
                        if (pend[andar_abaixo]) begin
                            st    <= ST_DOOR_OPEN;
                            out_q <= saidas(ST_DOOR_OPEN);
                        end else if (!abaixo) begin
                            st    <= ST_IDLE;
                            out_q <= saidas(ST_IDLE);
                        end
                    end
                end
                ST_DOOR_OPEN: begin
                    if (aceito) begin
                        cnt <= '0;
                    end else if (cnt == PORTA_FIM) begin
                        cnt   <= '0;
                        st    <= ch_st;
                        dir   <= ch_dir;
                        out_q <= saidas(ch_st);
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    st    <= ST_IDLE;
                    out_q <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend <= '0;
            npes <= '0;
        end else begin
            pend <= (pend | bus.req) & ~clr;
            if (st == ST_DOOR_OPEN) begin
                if (ent_ok)      npes <= npes + 1'b1;
                else if (sai_ok) npes <= npes - 1'b1;
            end
        end
    end

    assign bus.motor_up    = out_q[0];
    assign bus.motor_down  = out_q[1];
    assign bus.door_open   = out_q[2];
    assign bus.busy        = out_q[3];
    assign bus.direcao     = dir;
    assign bus.lotado      = lotado;
    assign bus.andar_atual = andar;
    assign bus.andar_alvo  = alvo;
    assign bus.pendentes   = pend;
    assign bus.num_people  = npes;

endmodule
